// File: rtl/blink_sequencer.sv
// Run/pause/step sequencer for the board LED counter: rate-selectable prescaler,
// up/down LED count with wrap flag, and a heartbeat that toggles on each timed tick.
module blink_sequencer #(
    parameter int TICK_DIV = 50_000_000,
    parameter int NUM_LEDS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                step,
    input  logic                dir,
    input  logic [1:0]          rate_sel,
    output logic [NUM_LEDS-1:0] led,
    output logic                tick,
    output logic                wrap,
    output logic                running,
    output logic                blink
);

    localparam int CW = $clog2(TICK_DIV);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    logic [1:0]          r_state;
    logic [CW-1:0]       r_presc;
    logic [NUM_LEDS-1:0] r_led;
    logic                r_tick;
    logic                r_wrap;
    logic                r_blink;

    logic [CW-1:0]       w_period_m1;
    logic                w_timed;
    logic [NUM_LEDS-1:0] w_led_next;
    logic                w_wrap_next;

    always_comb begin
        w_period_m1 = CW'(TICK_DIV - 1);
        case (rate_sel)
            2'd0:    w_period_m1 = CW'(TICK_DIV - 1);
            2'd1:    w_period_m1 = CW'(TICK_DIV / 2 - 1);
            2'd2:    w_period_m1 = CW'(TICK_DIV / 4 - 1);
            default: w_period_m1 = CW'(TICK_DIV / 8 - 1);
        endcase
    end

    // >= rather than == so a faster rate_sel never lets the prescaler overrun the new period
    assign w_timed     = (r_presc >= w_period_m1);
    assign w_led_next  = dir ? (r_led - NUM_LEDS'(1)) : (r_led + NUM_LEDS'(1));
    assign w_wrap_next = dir ? (r_led == '0) : (r_led == '1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_led   <= '0;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
            r_blink <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                    end else if (start) begin
                        r_state <= S_RUN;
                        r_presc <= '0;
                    end else if (step) begin
                        r_led  <= w_led_next;
                        r_tick <= 1'b1;
                        r_wrap <= w_wrap_next;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        r_state <= S_PAUSE;
                    end else if (w_timed) begin
                        r_presc <= '0;
                        r_led   <= w_led_next;
                        r_tick  <= 1'b1;
                        r_wrap  <= w_wrap_next;
                        r_blink <= ~r_blink;
                    end else begin
                        r_presc <= r_presc + CW'(1);
                    end
                end
                S_PAUSE: begin
                    // Second stop while paused is a full clear back to IDLE
                    if (stop) begin
                        r_state <= S_IDLE;
                        r_presc <= '0;
                        r_led   <= '0;
                        r_blink <= 1'b0;
                    end else if (start) begin
                        r_state <= S_RUN;
                    end else if (step) begin
                        r_led  <= w_led_next;
                        r_tick <= 1'b1;
                        r_wrap <= w_wrap_next;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign led     = r_led;
    assign tick    = r_tick;
    assign wrap    = r_wrap;
    assign blink   = r_blink;
    assign running = (r_state == S_RUN);

endmodule

// File: tb/tb_blink_sequencer.sv
// Scoreboarded bench for blink_sequencer at TICK_DIV=8, NUM_LEDS=4: each tick pops
// an expected (led, wrap, blink) record queued by the scenario that caused it.
module tb_blink_sequencer;

    typedef struct packed {
        logic [3:0] led;
        logic       wrap;
        logic       blink;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       step;
    logic       dir;
    logic [1:0] rate_sel;
    logic [3:0] led;
    logic       tick;
    logic       wrap;
    logic       running;
    logic       blink;

    int   checks;
    int   failures;
    ev_t  exp_q[$];
    logic exp_blink;

    blink_sequencer #(
        .TICK_DIV (8),
        .NUM_LEDS (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .step     (step),
        .dir      (dir),
        .rate_sel (rate_sel),
        .led      (led),
        .tick     (tick),
        .wrap     (wrap),
        .running  (running),
        .blink    (blink)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: every observed tick must match the oldest queued expectation
    always @(negedge clk) begin
        ev_t got;
        ev_t want;
        if (rst === 1'b1 && tick === 1'b1) begin
            got = '{led: led, wrap: wrap, blink: blink};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_tick led=%0d wrap=%0b blink=%0b (none expected)", led, wrap, blink);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    failures++;
                    $display("FAIL tick_event got led=%0d wrap=%0b blink=%0b want led=%0d wrap=%0b blink=%0b",
                             got.led, got.wrap, got.blink, want.led, want.wrap, want.blink);
                end else begin
                    $display("tick led=%0d wrap=%0b blink=%0b ok", got.led, got.wrap, got.blink);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input logic [3:0] l, input logic w, input logic b);
        ev_t ev;
        ev.led   = l;
        ev.wrap  = w;
        ev.blink = b;
        exp_q.push_back(ev);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b0; stop = 1'b0; step = 1'b0; dir = 1'b0; rate_sel = 2'd0;
        exp_blink = 1'b0;
        repeat (3) cyc();
        checks++;
        if ({led, tick, wrap, running, blink} !== 8'h00) begin
            failures++;
            $display("FAIL reset_state got led=%0d tick=%0b wrap=%0b running=%0b blink=%0b want all 0",
                     led, tick, wrap, running, blink);
        end
        rst = 1'b1;
        cyc();
        checks++;
        if (running !== 1'b0 || tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got running=%0b tick=%0b want 0 0", running, tick);
        end
        $display("test_reset done");
    endtask

    task automatic test_run();
        logic want_tick;
        dir = 1'b0;
        rate_sel = 2'd0;
        for (int k = 1; k <= 5; k++) begin
            exp_blink = ~exp_blink;
            push_ev(4'(k), 1'b0, exp_blink);
        end
        start = 1'b1; cyc(); start = 1'b0;
        checks++;
        if (running !== 1'b1) begin
            failures++;
            $display("FAIL run_running got %0b want 1", running);
        end
        for (int n = 1; n <= 40; n++) begin
            cyc();
            want_tick = (n % 8 == 0);
            checks++;
            if (tick !== want_tick) begin
                failures++;
                $display("FAIL run_tick_timing cycle=%0d got %0b want %0b", n, tick, want_tick);
            end
        end
        checks++;
        if (led !== 4'd5 || blink !== 1'b1) begin
            failures++;
            $display("FAIL run_led_blink got led=%0d blink=%0b want led=5 blink=1", led, blink);
        end
        $display("test_run done led=%0d", led);
    endtask

    task automatic test_wrap();
        for (int k = 6; k <= 15; k++) begin
            exp_blink = ~exp_blink;
            push_ev(4'(k), 1'b0, exp_blink);
        end
        exp_blink = ~exp_blink;
        push_ev(4'd0, 1'b1, exp_blink);
        repeat (88) cyc();
        checks++;
        if (led !== 4'd0) begin
            failures++;
            $display("FAIL wrap_up_led got %0d want 0", led);
        end
        dir = 1'b1;
        exp_blink = ~exp_blink;
        push_ev(4'd15, 1'b1, exp_blink);
        repeat (8) cyc();
        checks++;
        if (led !== 4'd15 || wrap !== 1'b1 || tick !== 1'b1) begin
            failures++;
            $display("FAIL wrap_down got led=%0d wrap=%0b tick=%0b want 15 1 1", led, wrap, tick);
        end
        $display("test_wrap done led=%0d", led);
    endtask

    task automatic test_pause_resume();
        logic want_tick;
        repeat (3) cyc();
        stop = 1'b1; cyc(); stop = 1'b0;
        checks++;
        if (running !== 1'b0) begin
            failures++;
            $display("FAIL pause_running got %0b want 0", running);
        end
        for (int n = 0; n < 20; n++) begin
            cyc();
            checks++;
            if (tick !== 1'b0 || led !== 4'd15) begin
                failures++;
                $display("FAIL pause_frozen cycle=%0d got tick=%0b led=%0d want 0 15", n, tick, led);
            end
        end
        dir = 1'b0;
        exp_blink = ~exp_blink;
        push_ev(4'd0, 1'b1, exp_blink);
        start = 1'b1; cyc(); start = 1'b0;
        // Prescaler held at 3, so the remaining count is 5 cycles
        for (int n = 1; n <= 5; n++) begin
            cyc();
            want_tick = (n == 5);
            checks++;
            if (tick !== want_tick) begin
                failures++;
                $display("FAIL resume_tick_timing cycle=%0d got %0b want %0b", n, tick, want_tick);
            end
        end
        $display("test_pause_resume done led=%0d", led);
    endtask

    task automatic test_clear_step();
        exp_blink = ~exp_blink;
        push_ev(4'd1, 1'b0, exp_blink);
        repeat (8) cyc();
        stop = 1'b1; cyc(); stop = 1'b0;
        cyc();
        stop = 1'b1; cyc(); stop = 1'b0;
        exp_blink = 1'b0;
        checks++;
        if (led !== 4'd0 || blink !== 1'b0 || running !== 1'b0) begin
            failures++;
            $display("FAIL clear_to_idle got led=%0d blink=%0b running=%0b want 0 0 0", led, blink, running);
        end
        for (int k = 1; k <= 3; k++) push_ev(4'(k), 1'b0, 1'b0);
        step = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            checks++;
            if (tick !== 1'b1 || led !== 4'(k)) begin
                failures++;
                $display("FAIL step_back_to_back step=%0d got tick=%0b led=%0d want 1 %0d", k, tick, led, k);
            end
        end
        step = 1'b0;
        cyc();
        checks++;
        if (tick !== 1'b0 || led !== 4'd3 || running !== 1'b0) begin
            failures++;
            $display("FAIL step_settle got tick=%0b led=%0d running=%0b want 0 3 0", tick, led, running);
        end
        $display("test_clear_step done led=%0d", led);
    endtask

    task automatic test_priority();
        start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
        checks++;
        if (running !== 1'b0) begin
            failures++;
            $display("FAIL start_stop_idle got running=%0b want 0", running);
        end
        for (int n = 0; n < 10; n++) begin
            cyc();
            checks++;
            if (tick !== 1'b0) begin
                failures++;
                $display("FAIL idle_no_tick cycle=%0d got tick=%0b want 0", n, tick);
            end
        end
        start = 1'b1; cyc(); start = 1'b0;
        repeat (2) cyc();
        step = 1'b1; cyc(); step = 1'b0;
        checks++;
        if (tick !== 1'b0 || led !== 4'd3 || running !== 1'b1) begin
            failures++;
            $display("FAIL run_step_ignored got tick=%0b led=%0d running=%0b want 0 3 1", tick, led, running);
        end
        $display("test_priority done");
    endtask

    task automatic test_rate_and_reset();
        repeat (2) cyc();
        rate_sel = 2'd3;
        for (int k = 4; k <= 7; k++) begin
            exp_blink = ~exp_blink;
            push_ev(4'(k), 1'b0, exp_blink);
        end
        for (int k = 4; k <= 7; k++) begin
            cyc();
            checks++;
            if (tick !== 1'b1 || led !== 4'(k)) begin
                failures++;
                $display("FAIL rate_fast_tick got tick=%0b led=%0d want 1 %0d", tick, led, k);
            end
        end
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({led, tick, wrap, running, blink} !== 8'h00) begin
            failures++;
            $display("FAIL async_reset got led=%0d tick=%0b wrap=%0b running=%0b blink=%0b want all 0",
                     led, tick, wrap, running, blink);
        end
        repeat (2) cyc();
        rate_sel = 2'd0;
        rst = 1'b1;
        exp_blink = 1'b0;
        for (int n = 0; n < 12; n++) begin
            cyc();
            checks++;
            if (tick !== 1'b0 || running !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_idle cycle=%0d got tick=%0b running=%0b want 0 0", n, tick, running);
            end
        end
        $display("test_rate_and_reset done");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_run();
        test_wrap();
        test_pause_resume();
        test_clear_step();
        test_priority();
        test_rate_and_reset();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending events want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
